// File: rtl/axi_bfm_pkg.sv
// Shared AXI encodings, FSM state types and helpers for the slave memory BFM.
package axi_bfm_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Encodings are ordered by severity, so the worse response is the larger one.
  function automatic resp_e resp_merge(input resp_e a, input resp_e b);
    if (a > b) return a;
    return b;
  endfunction

endpackage

// File: rtl/axi_slv_ready_lfsr.sv
// Pseudo-random stall generator for the slave BFM handshake outputs (used under AXI_SLV_BACKPRESSURE_EN).
module axi_slv_ready_lfsr
  import axi_bfm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic awready_in,
  input  logic wready_in,
  input  logic arready_in,
  input  logic rvalid_in,
  input  logic rready,
  output logic awready_out,
  output logic wready_out,
  output logic arready_out,
  output logic rvalid_out
);

  logic [15:0] lfsr;
  logic        r_shown;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= LFSR_SEED;
      r_shown <= 1'b0;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      r_shown <= rvalid_out && !rready;
    end
  end

  assign awready_out = awready_in && !lfsr[0];
  assign wready_out  = wready_in  && !lfsr[5];
  assign arready_out = arready_in && !lfsr[9];
  // A beat already presented stays visible until it is taken.
  assign rvalid_out  = rvalid_in && (r_shown || !lfsr[14]);

endmodule

// File: rtl/axi_slave_mem_bfm.sv
// AXI4 slave memory model with independent read/write FSMs, one burst in flight per direction.
// Optional random handshake stalls: define AXI_SLV_BACKPRESSURE_EN.
module axi_slave_mem_bfm
  import axi_bfm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [MASK_WIDTH-1:0] wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int unsigned SHIFT = $clog2(MASK_WIDTH);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic unused_sizes;
  assign unused_sizes = ^{awsize, arsize};

  function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) >> SHIFT;
  endfunction

  function automatic logic mem_access(input logic [ADDR_WIDTH-1:0] idx, input burst_e b);
    return (idx < ADDR_WIDTH'(MEM_WORDS)) && (b == BURST_INCR || b == BURST_FIXED);
  endfunction

  function automatic resp_e beat_resp(input logic [ADDR_WIDTH-1:0] idx, input burst_e b);
    if (idx >= ADDR_WIDTH'(MEM_WORDS)) return RESP_DECERR;
    if (b != BURST_INCR && b != BURST_FIXED) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_WIDTH-1:0] idx,
                                                      input burst_e b);
    if (mem_access(idx, b)) return mem[idx[IDX_W-1:0]];
    return '0;
  endfunction

  logic awready_q, wready_q, arready_q, rvalid_q;

`ifdef AXI_SLV_BACKPRESSURE_EN
  axi_slv_ready_lfsr u_lfsr (
    .clk         (clk),
    .rst_n       (rst_n),
    .awready_in  (awready_q),
    .wready_in   (wready_q),
    .arready_in  (arready_q),
    .rvalid_in   (rvalid_q),
    .rready      (rready),
    .awready_out (awready),
    .wready_out  (wready),
    .arready_out (arready),
    .rvalid_out  (rvalid)
  );
`else
  assign awready = awready_q;
  assign wready  = wready_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
`endif

  // ---------------- write path ----------------
  wr_state_e             w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_idx;
  burst_e                w_burst;
  logic [7:0]            w_len, w_cnt;
  resp_e                 w_resp, w_beat_resp, w_resp_next;
  logic                  w_hs;

  assign w_hs = wvalid && wready;

  always_comb begin
    w_beat_resp = beat_resp(w_idx, w_burst);
    if (wlast != (w_cnt == w_len)) w_beat_resp = resp_merge(w_beat_resp, RESP_SLVERR);
    w_resp_next = resp_merge(w_resp, w_beat_resp);
  end

  always_ff @(posedge clk) begin
    if (w_state == W_DATA && w_hs && mem_access(w_idx, w_burst)) begin
      for (int unsigned b = 0; b < MASK_WIDTH; b++) begin
        if (wstrb[b]) mem[w_idx[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= '0;
      w_id      <= '0;
      w_idx     <= '0;
      w_burst   <= BURST_FIXED;
      w_len     <= '0;
      w_cnt     <= '0;
      w_resp    <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awvalid && awready) begin
            w_id      <= awid;
            w_idx     <= word_of(awaddr);
            w_burst   <= burst_e'(awburst);
            w_len     <= awlen;
            w_cnt     <= '0;
            w_resp    <= RESP_OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_resp <= w_resp_next;
            if (w_burst == BURST_INCR) w_idx <= w_idx + 1'b1;
            // The beat counter, not wlast, decides where the burst ends.
            if (w_cnt == w_len) begin
              wready_q <= 1'b0;
              bvalid   <= 1'b1;
              bresp    <= w_resp_next;
              bid      <= w_id;
              w_state  <= W_RESP;
            end else begin
              w_cnt <= w_cnt + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid    <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  rd_state_e             r_state;
  logic [ADDR_WIDTH-1:0] r_idx, r_nidx, ar_idx;
  burst_e                r_burst, ar_burst;
  logic [7:0]            r_len, r_cnt;

  assign ar_idx   = word_of(araddr);
  assign ar_burst = burst_e'(arburst);
  assign r_nidx   = (r_burst == BURST_INCR) ? r_idx + 1'b1 : r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid       <= '0;
      rdata     <= '0;
      rresp     <= '0;
      rlast     <= 1'b0;
      r_idx     <= '0;
      r_burst   <= BURST_FIXED;
      r_len     <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arvalid && arready) begin
            rid       <= arid;
            r_idx     <= ar_idx;
            r_burst   <= ar_burst;
            r_len     <= arlen;
            r_cnt     <= '0;
            rdata     <= beat_data(ar_idx, ar_burst);
            rresp     <= beat_resp(ar_idx, ar_burst);
            rlast     <= (arlen == 8'd0);
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && rready) begin
            if (r_cnt == r_len) begin
              rvalid_q  <= 1'b0;
              rlast     <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_idx <= r_nidx;
              r_cnt <= r_cnt + 8'd1;
              rdata <= beat_data(r_nidx, r_burst);
              rresp <= beat_resp(r_nidx, r_burst);
              rlast <= (r_cnt + 8'd1 == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
